pc_sequencer: RTL

//  Parametrised program-counter sequencer for the multicycle core; next generation of the PC/branch-load logic.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ras_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core's PC path.
//   - opcode encodings for the control-flow instructions (instruction[15:12])
//   - default PC width
//   - ras_cnt_w(): width needed to hold a return-stack count of 0..depth
package cpu_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [3:0] OP_BGT  = 4'b1000;
    localparam logic [3:0] OP_BLT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_CALL = 4'b1101;
    localparam logic [3:0] OP_RET  = 4'b1110;

    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointer/count only)
//   push, pop         one-cycle strobes; never asserted together by the sequencer
//   din               address pushed on push
//   top               most recent entry (valid when !empty)
//   count/full/empty  occupancy status
// Pushing while full overwrites the oldest entry: when full, the write pointer
// already points at the oldest slot, so a plain write does the job and count
// saturates at DEPTH. Popping while empty is ignored here (caller flags it).
module ras_stack
    import cpu_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic                            pop,
    input  logic [PC_W-1:0]                 din,
    output logic [PC_W-1:0]                 top,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0] count,
    output logic                            full,
    output logic                            empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = ras_cnt_w(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;      // next slot to write
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] wr_ptr_dec;  // slot holding the top entry

    assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign wr_ptr_dec = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;

    assign full  = (count == CNT_W'(RAS_DEPTH));
    assign empty = (count == '0);
    assign top   = mem[wr_ptr_dec];

    // Storage is deliberately not reset; count=0 hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr_dec;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with hardware return-address stack.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   step             commit this instruction's PC update on this edge
//   opcode           instruction[15:12]
//   z, n, v          ALU flags of the current instruction
//   target           branch/jump/call destination
//   clr_flags        clear sticky ras_ovf/ras_unf (a simultaneous set wins)
//   pc               registered PC
//   pc_next          value pc takes if step=1 (combinational)
//   taken            current opcode redirects (combinational)
//   redirect         registered: previous edge committed a taken redirect
//   ras_count/full/empty  stack occupancy
//   ras_ovf/ras_unf  sticky push-while-full / pop-while-empty
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEF,
    parameter int          RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int          PC_INC    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            step,
    input  logic [3:0]                      opcode,
    input  logic                            z,
    input  logic                            n,
    input  logic                            v,
    input  logic [PC_W-1:0]                 target,
    input  logic                            clr_flags,
    output logic [PC_W-1:0]                 pc,
    output logic [PC_W-1:0]                 pc_next,
    output logic                            taken,
    output logic                            redirect,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count,
    output logic                            ras_full,
    output logic                            ras_empty,
    output logic                            ras_ovf,
    output logic                            ras_unf
);

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] ras_top;
    logic            is_call;
    logic            is_ret;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            unf_set;

    assign seq     = pc + PC_W'(PC_INC);  // wraps mod 2^PC_W
    assign is_call = (opcode == OP_CALL);
    assign is_ret  = (opcode == OP_RET);
    assign push    = step && is_call;
    assign pop     = step && is_ret && !ras_empty;
    assign ovf_set = push && ras_full;
    assign unf_set = step && is_ret && ras_empty;

    always_comb begin
        taken   = 1'b0;
        pc_next = seq;
        unique case (opcode)
            OP_BGT:  taken = !z && (n == v);
            OP_BLT:  taken = n ^ v;
            OP_BEQ:  taken = z;
            OP_BNE:  taken = !z;
            OP_JMP:  taken = 1'b1;
            OP_CALL: taken = 1'b1;
            OP_RET:  taken = !ras_empty;
            default: taken = 1'b0;
        endcase
        if (taken) begin
            pc_next = is_ret ? ras_top : target;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else begin
            if (step) begin
                pc <= pc_next;
            end
            redirect <= step && taken;
            // A new event in the same cycle as clr_flags keeps the flag set.
            if (ovf_set) begin
                ras_ovf <= 1'b1;
            end else if (clr_flags) begin
                ras_ovf <= 1'b0;
            end
            if (unf_set) begin
                ras_unf <= 1'b1;
            end else if (clr_flags) begin
                ras_unf <= 1'b0;
            end
        end
    end

endmodule
